// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage data-SRAM sequencer; DMEM_ALIGN_CHECK_EN enables misalignment traps
module dmem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mem_lsop,
  input  logic [31:0] mem_memaddr,
  input  logic [31:0] mem_reg2,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [31:0] data_sram_addr,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        stallreq_mem,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        adel,
  output logic        ades
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, next;
  logic [31:0] rdata_q;
  logic is_ld, is_st, is_half, is_word, mis, acc, req;
  logic [7:0] sel_b;
  logic [15:0] sel_h;
  assign is_ld   = mem_lsop >= 4'd1 && mem_lsop <= 4'd5;
  assign is_st   = mem_lsop >= 4'd6 && mem_lsop <= 4'd8;
  assign is_half = mem_lsop == 4'd3 || mem_lsop == 4'd4 || mem_lsop == 4'd7;
  assign is_word = mem_lsop == 4'd5 || mem_lsop == 4'd8;
`ifdef DMEM_ALIGN_CHECK_EN
  assign mis  = (is_half && mem_memaddr[0]) || (is_word && |mem_memaddr[1:0]);
  assign adel = mis && is_ld;
  assign ades = mis && is_st;
`else
  assign mis  = 1'b0;
  assign adel = 1'b0;
  assign ades = 1'b0;
`endif
  assign acc   = (is_ld || is_st) && !mis;
  assign req   = state == IDLE && acc;
  assign sel_b = data_sram_rdata_sel(rdata_q, mem_memaddr[1:0]);
  assign sel_h = mem_memaddr[1] ? rdata_q[31:16] : rdata_q[15:0];
  function automatic logic [7:0] data_sram_rdata_sel(input logic [31:0] w, input logic [1:0] a);
    return w[{a, 3'b000} +: 8];
  endfunction
  // state register and load-data capture; reset abandons any access in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rdata_q <= '0;
    end else begin
      state   <= next;
      if (state == WAIT && data_sram_data_ok) rdata_q <= data_sram_rdata;
    end
  end
  // next state: hold request until accepted, wait for response, one DONE cycle
  always_comb begin
    next = state == IDLE ? (req && data_sram_addr_ok ? WAIT : IDLE) :
           state == WAIT ? (data_sram_data_ok ? DONE : WAIT) : IDLE;
  end
  // outputs: bus fields only while requesting, load result only in DONE
  always_comb begin
    data_sram_req   = req;
    stallreq_mem    = req || state == WAIT;
    data_sram_wr    = req && is_st;
    data_sram_size  = !req ? 2'd0 : is_word ? 2'd2 : is_half ? 2'd1 : 2'd0;
    data_sram_addr  = req ? mem_memaddr : '0;
    data_sram_wstrb = !(req && is_st) ? 4'b0000 :
                      mem_lsop == 4'd6 ? 4'b0001 << mem_memaddr[1:0] :
                      mem_lsop == 4'd7 ? (mem_memaddr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    data_sram_wdata = !(req && is_st) ? 32'd0 :
                      mem_lsop == 4'd6 ? {4{mem_reg2[7:0]}} :
                      mem_lsop == 4'd7 ? {2{mem_reg2[15:0]}} : mem_reg2;
    load_valid      = state == DONE && is_ld;
    load_data       = !load_valid ? 32'd0 :
                      mem_lsop == 4'd1 ? {{24{sel_b[7]}}, sel_b} :
                      mem_lsop == 4'd2 ? {24'd0, sel_b} :
                      mem_lsop == 4'd3 ? {{16{sel_h[15]}}, sel_h} :
                      mem_lsop == 4'd4 ? {16'd0, sel_h} : rdata_q;
  end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed self-checking bench for dmem_access_ctrl
module tb_dmem_access_ctrl;
  logic clk = 0, rst = 1;
  logic [3:0] mem_lsop = 0;
  logic [31:0] mem_memaddr = 0, mem_reg2 = 0, data_sram_rdata = 0;
  logic data_sram_addr_ok = 0, data_sram_data_ok = 0;
  logic data_sram_req, data_sram_wr, stallreq_mem, load_valid, adel, ades;
  logic [1:0] data_sram_size;
  logic [31:0] data_sram_addr, data_sram_wdata, load_data;
  logic [3:0] data_sram_wstrb;
  int total = 0, bad = 0;

  dmem_access_ctrl dut (
    .clk(clk), .rst(rst), .mem_lsop(mem_lsop), .mem_memaddr(mem_memaddr), .mem_reg2(mem_reg2),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_addr(data_sram_addr), .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata), .stallreq_mem(stallreq_mem), .load_data(load_data),
    .load_valid(load_valid), .adel(adel), .ades(ades)
  );

  always #5 clk = ~clk;

  // drives one op; addr_ok after ad extra cycles, data_ok after dd extra WAIT cycles
  task automatic do_access(input logic [3:0] op, input logic [31:0] a, r2, rd, input int ad, dd,
                           output int stalls, reqs, output logic stable, lv, output logic [31:0] ld,
                           output logic w, output logic [1:0] sz, output logic [3:0] strb,
                           output logic [31:0] wd, ao);
    bit first = 1;
    stalls = 0; reqs = 0; stable = 1; lv = 0; ld = 0; w = 0; sz = 0; strb = 0; wd = 0; ao = 0;
    for (int c = 0; c < 30; c++) begin
      mem_lsop = op; mem_memaddr = a; mem_reg2 = r2; data_sram_rdata = rd;
      data_sram_addr_ok = (c == ad);
      data_sram_data_ok = (c == ad + 1 + dd);
      #1;
      if (data_sram_req) begin
        reqs++;
        if (first) begin
          w = data_sram_wr; sz = data_sram_size; strb = data_sram_wstrb; wd = data_sram_wdata; ao = data_sram_addr;
          first = 0;
        end else if ({w, sz, strb, wd, ao} !== {data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_wdata, data_sram_addr})
          stable = 0;
      end
      if (!stallreq_mem) begin
        lv = load_valid; ld = load_data;
        break;
      end
      stalls++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    mem_lsop = 0; data_sram_addr_ok = 0; data_sram_data_ok = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    #1;
    total++;
    if ({data_sram_req, data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata,
         stallreq_mem, load_data, load_valid, adel, ades} !== '0) begin
      bad++; $display("FAIL reset_outputs req=%b stall=%b lv=%b ld=%h", data_sram_req, stallreq_mem, load_valid, load_data);
    end
  endtask

  task automatic test_lw;
    int s, r; logic st, lv, w; logic [31:0] ld, wd, ao; logic [1:0] sz; logic [3:0] sb;
    do_access(4'd5, 32'h1000, 32'h0, 32'hDEADBEEF, 0, 0, s, r, st, lv, ld, w, sz, sb, wd, ao);
    total++; if (s !== 2) begin bad++; $display("FAIL lw_stalls got=%0d exp=2", s); end
    total++; if (r !== 1) begin bad++; $display("FAIL lw_reqs got=%0d exp=1", r); end
    total++; if ({w, sz, sb, ao} !== {1'b0, 2'd2, 4'b0000, 32'h1000}) begin
      bad++; $display("FAIL lw_fields got wr=%b size=%0d strb=%b addr=%h exp 0/2/0000/00001000", w, sz, sb, ao); end
    total++; if ({lv, ld} !== {1'b1, 32'hDEADBEEF}) begin
      bad++; $display("FAIL lw_data got lv=%b data=%h exp 1 deadbeef", lv, ld); end
  endtask

  task automatic test_extract;
    int s, r; logic st, lv, w; logic [31:0] ld, wd, ao; logic [1:0] sz; logic [3:0] sb;
    do_access(4'd1, 32'h1003, 32'h0, 32'h80112233, 0, 0, s, r, st, lv, ld, w, sz, sb, wd, ao);
    total++; if ({lv, ld} !== {1'b1, 32'hFFFFFF80}) begin bad++; $display("FAIL lb got lv=%b data=%h exp ffffff80", lv, ld); end
    total++; if (sz !== 2'd0) begin bad++; $display("FAIL lb_size got=%0d exp=0", sz); end
    do_access(4'd2, 32'h1003, 32'h0, 32'h80112233, 0, 0, s, r, st, lv, ld, w, sz, sb, wd, ao);
    total++; if ({lv, ld} !== {1'b1, 32'h00000080}) begin bad++; $display("FAIL lbu got lv=%b data=%h exp 00000080", lv, ld); end
    total++; if (s !== 2) begin bad++; $display("FAIL b2b_stalls got=%0d exp=2", s); end
    do_access(4'd3, 32'h1002, 32'h0, 32'h80112233, 0, 0, s, r, st, lv, ld, w, sz, sb, wd, ao);
    total++; if ({lv, ld} !== {1'b1, 32'hFFFF8011}) begin bad++; $display("FAIL lh got lv=%b data=%h exp ffff8011", lv, ld); end
    do_access(4'd4, 32'h1000, 32'h0, 32'h80118233, 0, 0, s, r, st, lv, ld, w, sz, sb, wd, ao);
    total++; if ({lv, ld} !== {1'b1, 32'h00008233}) begin bad++; $display("FAIL lhu got lv=%b data=%h exp 00008233", lv, ld); end
    total++; if (sz !== 2'd1) begin bad++; $display("FAIL lhu_size got=%0d exp=1", sz); end
  endtask

  task automatic test_store;
    int s, r; logic st, lv, w; logic [31:0] ld, wd, ao; logic [1:0] sz; logic [3:0] sb;
    do_access(4'd7, 32'h2002, 32'h1234ABCD, 32'h0, 0, 0, s, r, st, lv, ld, w, sz, sb, wd, ao);
    total++; if ({w, sz, sb, wd} !== {1'b1, 2'd1, 4'b1100, 32'hABCDABCD}) begin
      bad++; $display("FAIL sh_hi got wr=%b size=%0d strb=%b wdata=%h exp 1/1/1100/abcdabcd", w, sz, sb, wd); end
    total++; if (lv !== 1'b0) begin bad++; $display("FAIL sh_lv got=%b exp=0", lv); end
    do_access(4'd6, 32'h2001, 32'h123456CD, 32'h0, 0, 0, s, r, st, lv, ld, w, sz, sb, wd, ao);
    total++; if ({w, sz, sb, wd} !== {1'b1, 2'd0, 4'b0010, 32'hCDCDCDCD}) begin
      bad++; $display("FAIL sb got wr=%b size=%0d strb=%b wdata=%h exp 1/0/0010/cdcdcdcd", w, sz, sb, wd); end
    do_access(4'd8, 32'h2004, 32'hCAFEF00D, 32'h0, 0, 0, s, r, st, lv, ld, w, sz, sb, wd, ao);
    total++; if ({w, sz, sb, wd, ao} !== {1'b1, 2'd2, 4'b1111, 32'hCAFEF00D, 32'h2004}) begin
      bad++; $display("FAIL sw got wr=%b size=%0d strb=%b wdata=%h addr=%h", w, sz, sb, wd, ao); end
    do_access(4'd7, 32'h2000, 32'h00005A5A, 32'h0, 0, 0, s, r, st, lv, ld, w, sz, sb, wd, ao);
    total++; if (sb !== 4'b0011) begin bad++; $display("FAIL sh_lo got strb=%b exp=0011", sb); end
  endtask

  task automatic test_slow_bus;
    int s, r; logic st, lv, w; logic [31:0] ld, wd, ao; logic [1:0] sz; logic [3:0] sb;
    do_access(4'd5, 32'h3000, 32'h0, 32'h01020304, 3, 1, s, r, st, lv, ld, w, sz, sb, wd, ao);
    total++; if (r !== 4) begin bad++; $display("FAIL slow_reqs got=%0d exp=4", r); end
    total++; if (st !== 1'b1) begin bad++; $display("FAIL slow_stable got=%b exp=1", st); end
    total++; if (s !== 6) begin bad++; $display("FAIL slow_stalls got=%0d exp=6", s); end
    total++; if ({lv, ld} !== {1'b1, 32'h01020304}) begin bad++; $display("FAIL slow_data got lv=%b data=%h", lv, ld); end
    #1;
    total++; if ({data_sram_req, stallreq_mem} !== 2'b00) begin
      bad++; $display("FAIL slow_after got req=%b stall=%b exp 0 0", data_sram_req, stallreq_mem); end
  endtask

  task automatic test_nonaccess;
    int s, r; logic st, lv, w; logic [31:0] ld, wd, ao; logic [1:0] sz; logic [3:0] sb;
    do_access(4'd0, 32'h1000, 32'h0, 32'h0, 0, 0, s, r, st, lv, ld, w, sz, sb, wd, ao);
    total++; if ({s, r} !== {32'd0, 32'd0}) begin bad++; $display("FAIL op0 got stalls=%0d reqs=%0d exp 0 0", s, r); end
    do_access(4'd12, 32'h1000, 32'h0, 32'h0, 0, 0, s, r, st, lv, ld, w, sz, sb, wd, ao);
    total++; if ({s, r} !== {32'd0, 32'd0}) begin bad++; $display("FAIL op12 got stalls=%0d reqs=%0d exp 0 0", s, r); end
  endtask

  task automatic test_reset_mid;
    mem_lsop = 4'd5; mem_memaddr = 32'h4000; data_sram_addr_ok = 1;
    @(posedge clk); #1;
    data_sram_addr_ok = 0;
    total++; if ({data_sram_req, stallreq_mem} !== 2'b01) begin
      bad++; $display("FAIL mid_wait got req=%b stall=%b exp 0 1", data_sram_req, stallreq_mem); end
    rst = 1; mem_lsop = 0;
    @(posedge clk); #1;
    rst = 0; #1;
    total++; if ({data_sram_req, stallreq_mem, load_valid, load_data, adel, ades} !== '0) begin
      bad++; $display("FAIL mid_reset got req=%b stall=%b lv=%b", data_sram_req, stallreq_mem, load_valid); end
    data_sram_data_ok = 1; data_sram_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    data_sram_data_ok = 0; mem_lsop = 4'd5; #1;
    total++; if ({load_valid, stallreq_mem, data_sram_req} !== 3'b011) begin
      bad++; $display("FAIL mid_late_ok got lv=%b stall=%b req=%b exp 0 1 1", load_valid, stallreq_mem, data_sram_req); end
    mem_lsop = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_misaligned;
    mem_lsop = 4'd5; mem_memaddr = 32'h1001; data_sram_addr_ok = 0; #1;
`ifdef DMEM_ALIGN_CHECK_EN
    total++; if ({adel, ades, data_sram_req, stallreq_mem} !== 4'b1000) begin
      bad++; $display("FAIL mis_lw got adel=%b ades=%b req=%b stall=%b exp 1 0 0 0", adel, ades, data_sram_req, stallreq_mem); end
    mem_lsop = 4'd8; mem_memaddr = 32'h1002; #1;
    total++; if ({adel, ades, data_sram_req, stallreq_mem} !== 4'b0100) begin
      bad++; $display("FAIL mis_sw got adel=%b ades=%b req=%b stall=%b exp 0 1 0 0", adel, ades, data_sram_req, stallreq_mem); end
`else
    total++; if ({adel, data_sram_req, data_sram_addr} !== {1'b0, 1'b1, 32'h1001}) begin
      bad++; $display("FAIL mis_lw got adel=%b req=%b addr=%h exp 0 1 00001001", adel, data_sram_req, data_sram_addr); end
`endif
    mem_lsop = 0; #1;
  endtask

  initial begin
    test_reset;
    test_lw;
    test_extract;
    test_store;
    test_slow_bus;
    test_nonaccess;
    test_reset_mid;
    test_misaligned;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

MEM-stage data-memory sequencer for the 5-stage SRAM-interface CPU. Takes the load/store operation latched in the EX/MEM pipeline register, drives a request/response data-SRAM bus, holds the pipeline through `stallreq_mem` until the access completes, and returns sign- or zero-extended load data for MEM/WB. It is the only master of the data SRAM port.

## Interface
Parameters: none.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `mem_lsop` in 4: op from EX/MEM. 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9–15 are treated as none.
- `mem_memaddr` in 32: byte address.
- `mem_reg2` in 32: store source register.
- `data_sram_req` out 1: request valid.
- `data_sram_wr` out 1: 1 = write.
- `data_sram_size` out 2: 0 byte, 1 half, 2 word.
- `data_sram_addr` out 32: address.
- `data_sram_wstrb` out 4: byte enables.
- `data_sram_wdata` out 32: store data.
- `data_sram_addr_ok` in 1: request accepted this cycle.
- `data_sram_data_ok` in 1: read data valid or write acknowledged.
- `data_sram_rdata` in 32: read data.
- `stallreq_mem` out 1: MEM-stage stall request to the pipeline controller.
- `load_data` out 32: extended load result.
- `load_valid` out 1: `load_data` is valid this cycle.
- `adel` out 1: misaligned load detected.
- `ades` out 1: misaligned store detected.

## Operation
- FSM with three states: IDLE, WAIT, DONE.
- An access op is any op 1–8 that is aligned, or any op 1–8 when alignment checking is compiled out.
- **IDLE:**
  - If an access op is present, `data_sram_req`=1 and `stallreq_mem`=1.
  - If `addr_ok`=1, go to WAIT. Otherwise stay in IDLE and keep the request asserted.
  - With no access op, all outputs are 0.
- **WAIT:**
  - `req`=0, `stallreq_mem`=1.
  - On `data_ok`=1: capture `rdata` into an internal register and go to DONE.
- **DONE:**
  - `stallreq_mem`=0.
  - For loads, `load_valid`=1 and `load_data` comes from the captured register.
  - Transition to IDLE unconditionally. The pipeline advances on this edge, so the same op is never reissued.
- **Request fields:**
  - `addr` = `mem_memaddr` unmodified.
  - `size` follows from the op.
  - `wr`=1 for ops 6–8.
- **Store strobes and data:**
  - SB: `wstrb` = 1 << addr[1:0]; `wdata` = reg2[7:0] replicated ×4.
  - SH: `wstrb` = 4'b0011 when addr[1]=0, else 4'b1100; `wdata` = reg2[15:0] replicated ×2.
  - SW: `wstrb` = 4'b1111; `wdata` = reg2.
  - Loads: `wstrb`=0.
- **Load extraction:** select the byte or half from the captured word using addr[1:0].
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW passes the word through.
- `data_ok` in IDLE or DONE is ignored.
- `addr_ok` outside an active request is ignored.

## Timing
- **Reset:** state=IDLE and the capture register is cleared. Every output is 0 in the cycle after reset, including `req`, `stallreq_mem`, `load_valid`, `adel` and `ades`.
- **Reset mid-access:** abandons the access; the bus slave is reset by the same `rst`.
- **Minimum access:**
  - Cycle 0: IDLE with `addr_ok`=1.
  - Cycle 1: WAIT with `data_ok`=1.
  - Cycle 2: DONE.
  - This gives 2 stall cycles.
- **Stall count:** each extra cycle without `addr_ok` or `data_ok` adds exactly one stall cycle.
- **`stallreq_mem`** is combinational from state and op. It is high in the same cycle a new access op appears.
- **Back-to-back accesses:** the next op enters IDLE on the cycle after DONE. No idle bubble is required.
- **Non-access ops** (0, 9–15, misaligned): zero stall cycles, `req` never asserted.

## Configuration
- Macro: `DMEM_ALIGN_CHECK_EN`.
- **Defined:**
  - LH/LHU with addr[0]≠0, or LW with addr[1:0]≠0: `adel`=1 combinationally, no request, no stall.
  - SH with addr[0]≠0, or SW with addr[1:0]≠0: `ades`=1 combinationally, no request, no stall.
- **Undefined:** `adel` and `ades` are tied to 0, and every op 1–8 issues a request with the unmodified address.

## Test plan
- **Aligned LW:** LW addr 0x1000, `addr_ok` in cycle 0, `data_ok` in cycle 1 with rdata 0xDEADBEEF. Require stall high for 2 cycles, then `load_valid`=1 and `load_data`=0xDEADBEEF in DONE.
- **LB/LBU extraction:** LB addr 0x1003 with rdata 0x80112233 gives `load_data` 0xFFFFFF80. LBU at the same address gives 0x00000080.
- **SH to upper half:** SH addr 0x2002, reg2 0x1234ABCD. Require `wstrb` 4'b1100, `wdata` 0xABCDABCD, `wr`=1, `size`=1.
- **Slow bus:** `addr_ok` delayed 3 cycles and `data_ok` delayed 2 more. Require `req` held with fields stable for 4 cycles, `stallreq_mem` high for exactly 6 cycles, and no second request.
- **Reset mid-access:** `rst` asserted in WAIT. Next cycle state is IDLE and all outputs are 0; a late `data_ok` is ignored.
- **Misaligned LW (macro on):** LW addr 0x1001 with `DMEM_ALIGN_CHECK_EN`. Require `adel`=1, `req`=0, `stallreq_mem`=0. With the macro off, require a request at 0x1001 and `adel`=0.
